// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared types and helpers for the
// pattern-memory load controller.
package rom_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam int unsigned DEPTH = 256;

  // Limit a requested byte count to the memory depth.
  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned lim
  );
    return (len > lim) ? lim : len;
  endfunction

endpackage

// File: rtl/rom_mem_sp.sv
// rom_mem_sp: single-port RAM with one-cycle
// synchronous read, no reset on the array.
module rom_mem_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write when enabled; always register the addressed word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: clear/load sequencer and port arbiter
// for the pattern memory behind the lookup datapath.
module rom_load_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_cl;
  logic              w_turn;
  logic [DATA_W-1:0] rd_hold;

  logic              in_idle;
  logic              in_load;
  logic              clearing;
  logic              conflict;
  logic              grant_w;
  logic              grant_r;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign len_cl = CNT_W'(clamp_len(32'(ld_len), MEM_DEPTH));

  // Arbitrate the single port; w_turn alternates on conflicts,
  // so the first conflict after reset goes to the reader.
  always_comb begin
    in_idle   = !rst && (state == ST_IDLE);
    in_load   = !rst && (state == ST_LOAD);
    clearing  = !rst && (state == ST_CLEAR);
    conflict  = in_load && ld_valid && rd_req;
    grant_w   = in_load && ld_valid && (!rd_req || w_turn);
    grant_r   = rd_req &&
                (in_idle || (in_load && (!ld_valid || !w_turn)));
    mem_we    = clearing || grant_w;
    mem_addr  = rd_addr;
    if (clearing)     mem_addr = clr_ptr;
    else if (grant_w) mem_addr = wr_ptr;
    mem_wdata = clearing ? '0 : ld_data;
  end

  assign ld_ready = grant_w;
  assign rd_gnt   = grant_r;
  assign busy     = (state != ST_IDLE);
  assign rd_data  = rd_valid ? mem_rdata : rd_hold;

  // Sequencer: clear sweep, idle, and bounded load session.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_EN ? ST_CLEAR : ST_IDLE;
      clr_ptr  <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      w_turn   <= 1'b0;
      ld_done  <= 1'b0;
      rd_valid <= 1'b0;
      rd_hold  <= '0;
    end else begin
      ld_done  <= 1'b0;
      rd_valid <= grant_r;
      if (rd_valid) rd_hold <= mem_rdata;
      unique case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (&clr_ptr) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (ld_start) begin
            wr_ptr <= ld_base;
            cnt    <= len_cl;
            if (len_cl == '0) ld_done <= 1'b1;
            else              state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (conflict) w_turn <= !w_turn;
          if (grant_w) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state   <= ST_IDLE;
              ld_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rom_mem_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: directed bench for the pattern
// memory load controller (clear on and clear off).
module tb_rom_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_start;
  logic [7:0] ld_base;
  logic [8:0] ld_len;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic       busy;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_gnt;
  logic       rd_valid;
  logic [7:0] rd_data;

  logic       b_rst;
  logic       b_ld_start;
  logic [7:0] b_ld_base;
  logic [8:0] b_ld_len;
  logic       b_ld_valid;
  logic [7:0] b_ld_data;
  logic       b_ld_ready;
  logic       b_ld_done;
  logic       b_busy;
  logic       b_rd_req;
  logic [7:0] b_rd_addr;
  logic       b_rd_gnt;
  logic       b_rd_valid;
  logic [7:0] b_rd_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] pat [4];
  logic       seen_done;
  logic       all_busy;

  always #5 clk = ~clk;

  rom_load_ctrl #(.ADDR_W(8), .DATA_W(8), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .busy(busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  rom_load_ctrl #(.ADDR_W(8), .DATA_W(8), .CLEAR_EN(1'b0)) dut_nc (
    .clk(clk), .rst(b_rst),
    .ld_start(b_ld_start), .ld_base(b_ld_base), .ld_len(b_ld_len),
    .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_ready(b_ld_ready),
    .ld_done(b_ld_done), .busy(b_busy),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_gnt(b_rd_gnt),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lookup read from IDLE: grant now, data one cycle later.
  task automatic rd(input bit b, input logic [7:0] a,
                    input logic [7:0] e, input string tag);
    if (b) begin b_rd_req = 1'b1; b_rd_addr = a; end
    else   begin rd_req = 1'b1;   rd_addr = a;   end
    #1;
    chk({tag, "_gnt"}, b ? b_rd_gnt : rd_gnt, 1);
    cyc();
    if (b) b_rd_req = 1'b0;
    else   rd_req = 1'b0;
    chk({tag, "_vld"}, b ? b_rd_valid : rd_valid, 1);
    chk({tag, "_dat"}, b ? b_rd_data : rd_data, e);
  endtask

  initial begin
    pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rst = 1'b1; ld_start = 0; ld_base = 0; ld_len = 0;
    ld_valid = 0; ld_data = 0; rd_req = 0; rd_addr = 0;
    b_rst = 1'b1; b_ld_start = 0; b_ld_base = 0; b_ld_len = 0;
    b_ld_valid = 0; b_ld_data = 0; b_rd_req = 0; b_rd_addr = 0;

    // 1: reset and clear sweep
    cyc();
    rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_done", ld_done, 0);
    chk("rst_rvld", rd_valid, 0);
    chk("rst_rdat", rd_data, 0);
    chk("rst_rdy", ld_ready, 0);
    chk("nc_rst_busy", b_busy, 0);
    rd_req = 1'b1; rd_addr = 8'h40;
    #1;
    all_busy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk("clr_nognt", rd_gnt, 0);
      all_busy &= busy;
      cyc();
    end
    chk("clr_busy256", all_busy, 1);
    chk("clr_idle", busy, 0);
    chk("clr_idle_gnt", rd_gnt, 1);
    rd_req = 1'b0;
    cyc();
    rd(0, 8'h00, 8'h00, "clr_rd00");
    rd(0, 8'h7F, 8'h00, "clr_rd7f");
    rd(0, 8'hFF, 8'h00, "clr_rdff");

    // 2: wrapping load FE..01
    ld_start = 1; ld_base = 8'hFE; ld_len = 9'd4;
    #1;
    chk("t2_idle_rdy", ld_ready, 0);
    cyc();
    ld_start = 0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_data = pat[i];
      #1;
      chk("t2_rdy", ld_ready, 1);
      chk("t2_nodone", ld_done, 0);
      cyc();
    end
    ld_valid = 0;
    #1;
    chk("t2_done", ld_done, 1);
    chk("t2_busy", busy, 0);
    cyc();
    chk("t2_done_once", ld_done, 0);
    rd(0, 8'hFE, 8'hA1, "t2_rdfe");
    rd(0, 8'hFF, 8'hB2, "t2_rdff");
    rd(0, 8'h00, 8'hC3, "t2_rd00");
    rd(0, 8'h01, 8'hD4, "t2_rd01");

    // 3: conflicts alternate R,W,R,W starting with R
    ld_start = 1; ld_base = 8'h10; ld_len = 9'd3;
    cyc();
    ld_start = 0;
    rd_req = 1; rd_addr = 8'hFE; ld_valid = 1;
    for (int k = 0; k < 6; k++) begin
      ld_data = 8'h60 + 8'(k);
      #1;
      chk("t3_gnt", rd_gnt, (k % 2) == 0);
      chk("t3_rdy", ld_ready, (k % 2) == 1);
      chk("t3_rvld", rd_valid, (k % 2) == 1);
      if ((k % 2) == 1) chk("t3_rdat", rd_data, 8'hA1);
      cyc();
    end
    chk("t3_done", ld_done, 1);
    chk("t3_busy", busy, 0);
    rd_req = 0; ld_valid = 0;
    cyc();
    cyc();
    rd(0, 8'h10, 8'h61, "t3_rd10");
    rd(0, 8'h11, 8'h63, "t3_rd11");
    rd(0, 8'h12, 8'h65, "t3_rd12");

    // 4: zero-length session, then over-length clamp
    ld_start = 1; ld_base = 8'h30; ld_len = 9'd0;
    ld_valid = 1; ld_data = 8'hEE;
    cyc();
    ld_start = 0;
    chk("t4_z_done", ld_done, 1);
    chk("t4_z_busy", busy, 0);
    chk("t4_z_rdy", ld_ready, 0);
    ld_valid = 0;
    cyc();
    chk("t4_z_once", ld_done, 0);
    rd(0, 8'h30, 8'h00, "t4_z_rd30");
    ld_start = 1; ld_base = 8'h80; ld_len = 9'd300;
    cyc();
    ld_start = 0;
    seen_done = 0;
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1; ld_data = 8'(i) ^ 8'h5A;
      #1;
      chk("t4_rdy", ld_ready, 1);
      seen_done |= ld_done;
      cyc();
    end
    chk("t4_early_done", seen_done, 0);
    chk("t4_done", ld_done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_no257", ld_ready, 0);
    ld_valid = 0;
    cyc();
    rd(0, 8'h80, 8'h5A, "t4_rd80");
    rd(0, 8'h7F, 8'hA5, "t4_rd7f");
    rd(0, 8'hFE, 8'h24, "t4_rdfe");

    // 6: ld_start mid-session ignored; read-only grant in LOAD
    ld_start = 1; ld_base = 8'h20; ld_len = 9'd3;
    cyc();
    ld_start = 0;
    ld_valid = 1; ld_data = 8'h11;
    #1;
    chk("t6_rdy0", ld_ready, 1);
    cyc();
    ld_valid = 0;
    ld_start = 1; ld_base = 8'h40; ld_len = 9'd5;
    rd_req = 1; rd_addr = 8'h7F;
    #1;
    chk("t6_ld_gnt", rd_gnt, 1);
    chk("t6_ld_busy", busy, 1);
    cyc();
    ld_start = 0; rd_req = 0;
    chk("t6_rvld", rd_valid, 1);
    chk("t6_rdat", rd_data, 8'hA5);
    ld_valid = 1; ld_data = 8'h22;
    cyc();
    chk("t6_hold_vld", rd_valid, 0);
    chk("t6_hold_dat", rd_data, 8'hA5);
    ld_data = 8'h33;
    cyc();
    ld_valid = 0;
    chk("t6_done", ld_done, 1);
    chk("t6_busy", busy, 0);
    cyc();
    rd(0, 8'h20, 8'h11, "t6_rd20");
    rd(0, 8'h21, 8'h22, "t6_rd21");
    rd(0, 8'h22, 8'h33, "t6_rd22");
    rd(0, 8'h40, 8'h9A, "t6_rd40");

    // 5: reset mid-session with clear enabled
    ld_start = 1; ld_base = 8'h50; ld_len = 9'd5;
    cyc();
    ld_start = 0;
    ld_valid = 1; ld_data = 8'hAB;
    cyc();
    ld_data = 8'hCD;
    cyc();
    rst = 1; ld_data = 8'hEF;
    cyc();
    rst = 0; ld_valid = 0;
    chk("t5_busy", busy, 1);
    seen_done = 0;
    all_busy = 1;
    for (int i = 0; i < 256; i++) begin
      seen_done |= ld_done;
      all_busy &= busy;
      cyc();
    end
    chk("t5_no_done", seen_done, 0);
    chk("t5_clr_busy", all_busy, 1);
    chk("t5_idle", busy, 0);
    rd(0, 8'h50, 8'h00, "t5_rd50");
    rd(0, 8'h51, 8'h00, "t5_rd51");
    rd(0, 8'h80, 8'h00, "t5_rd80");

    // 5b: same with clear disabled keeps written bytes
    b_ld_start = 1; b_ld_base = 8'h50; b_ld_len = 9'd5;
    cyc();
    b_ld_start = 0;
    b_ld_valid = 1; b_ld_data = 8'hAB;
    #1;
    chk("t5b_rdy", b_ld_ready, 1);
    cyc();
    b_ld_data = 8'hCD;
    cyc();
    b_rst = 1; b_ld_data = 8'hEF;
    #1;
    chk("t5b_rst_rdy", b_ld_ready, 0);
    cyc();
    b_rst = 0; b_ld_valid = 0;
    chk("t5b_busy", b_busy, 0);
    chk("t5b_done", b_ld_done, 0);
    cyc();
    chk("t5b_done2", b_ld_done, 0);
    rd(1, 8'h50, 8'hAB, "t5b_rd50");
    rd(1, 8'h51, 8'hCD, "t5b_rd51");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
